// File: rtl/iso7816_rx_char.sv
// ISO7816 character receiver: start detect, mid-ETU sampling, T=0 NACK, valid/ack handoff.
// Optional ISO7816_RX_INVERSE_EN adds cfg_inverse for the inverse convention.
module iso7816_rx_char #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_in,
  output logic       io_oe,
  output logic       brg_sync,
  output logic       brg_run,
  input  logic       brg_stb_rx,
  input  logic       ena,
  input  logic       cfg_nack_en,
`ifdef ISO7816_RX_INVERSE_EN
  input  logic       cfg_inverse,
`endif
  output logic [7:0] rx_data,
  output logic       rx_perr,
  output logic       rx_ferr,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_ovf,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, NACK
  } state_t;

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   io_s;
  logic                   io_p_reg;
  logic                   fall;
  logic [7:0]             sreg_reg;
  logic [2:0]             bit_cnt_reg;
  logic                   perr_reg;
  logic                   bit_val;
  logic                   deliver;
  logic                   del_ferr;

`ifdef ISO7816_RX_INVERSE_EN
  logic inv_reg;
`else
  localparam logic inv_reg = 1'b0;
`endif

  // Chain presets to 1 so an idle-high line does not look like a start bit after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '1;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], io_in};
  end

  assign io_s     = sync_reg[SYNC_STAGES-1];
  assign fall     = io_p_reg & ~io_s;
  assign bit_val  = inv_reg ? ~io_s : io_s;
  assign busy     = (state_reg != IDLE);
  assign deliver  = ena && (state_reg == STOP) && brg_stb_rx;
  // On the NACK path the stop slot holds our own error signal, so it is never a framing error.
  assign del_ferr = ~(perr_reg & cfg_nack_en) & ~io_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      io_p_reg    <= 1'b1;
      io_oe       <= 1'b0;
      brg_sync    <= 1'b0;
      brg_run     <= 1'b0;
      sreg_reg    <= 8'h00;
      bit_cnt_reg <= 3'd0;
      perr_reg    <= 1'b0;
`ifdef ISO7816_RX_INVERSE_EN
      inv_reg     <= 1'b0;
`endif
    end else begin
      io_p_reg <= io_s;
      brg_sync <= 1'b0;
      if (!ena) begin
        state_reg <= IDLE;
        io_oe     <= 1'b0;
        brg_run   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (fall) begin
              state_reg <= START;
              brg_sync  <= 1'b1;
              brg_run   <= 1'b1;
`ifdef ISO7816_RX_INVERSE_EN
              inv_reg   <= cfg_inverse;
`endif
            end
          end
          START: begin
            if (brg_stb_rx) begin
              if (io_s) begin
                state_reg <= IDLE;
                brg_run   <= 1'b0;
              end else begin
                state_reg   <= DATA;
                bit_cnt_reg <= 3'd0;
              end
            end
          end
          DATA: begin
            if (brg_stb_rx) begin
              if (inv_reg) sreg_reg <= {sreg_reg[6:0], bit_val};
              else         sreg_reg <= {bit_val, sreg_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
            end
          end
          PARITY: begin
            if (brg_stb_rx) begin
              perr_reg  <= ^{sreg_reg, bit_val};
              state_reg <= STOP;
            end
          end
          STOP: begin
            if (brg_stb_rx) begin
              if (perr_reg && cfg_nack_en) begin
                io_oe     <= 1'b1;
                state_reg <= NACK;
              end else begin
                state_reg <= IDLE;
                brg_run   <= 1'b0;
              end
            end
          end
          NACK: begin
            if (brg_stb_rx) begin
              io_oe     <= 1'b0;
              state_reg <= IDLE;
              brg_run   <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            io_oe     <= 1'b0;
            brg_run   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Host handoff; a pop in the same cycle as a new byte keeps rx_valid without overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_valid <= 1'b0;
      rx_ovf   <= 1'b0;
    end else if (deliver) begin
      rx_data  <= sreg_reg;
      rx_perr  <= perr_reg;
      rx_ferr  <= del_ferr;
      rx_valid <= 1'b1;
      if (rx_valid && !rx_ack) rx_ovf <= 1'b1;
      else if (rx_ack)         rx_ovf <= 1'b0;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
      rx_ovf   <= 1'b0;
    end
  end

endmodule
